tc_uart_io: RTL and testbench
=============================

Name: tc_uart_io

Overview:
- Peripheral (responder) end of the TinyComp I/O interface: answers the processor's InStrobe/OutStrobe/InRdy/InData handshake and bridges it to an 8N1 UART.
- Output words captured on OutStrobe go into a small FIFO; bits [7:0] of each word are serialized on Txd.
- Bytes received on Rxd land in a holding register that the processor polls via InRdy (skip test) and reads via InStrobe.

Parameters:
- ClkDiv, 434, Ph0 cycles per UART bit (50 MHz / 115200); legal range 16..65535.
- TxDepth, 4, output FIFO depth in words; power of two, minimum 2.

Ports:
- Ph0  in  1  single system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset (low = reset).
- OutStrobe  in  1  processor executing Output this cycle.
- OutData  in  32  output word (processor port-A register value), valid when OutStrobe=1.
- InStrobe  in  1  processor executing Input this cycle.
- InData  out  32  input word, combinational from registered state.
- InRdy  out  1  received byte available (= RxValid).
- Txd  out  1  UART transmit line, idle high.
- Rxd  in  1  UART receive line, asynchronous.

Behaviour:
- Reset values: Txd=1, InRdy=0, InData=0, FIFO empty, all sticky flags 0, both UART engines idle.
- Each strobe is a single Ph0 cycle (one instruction). Its effect happens at the rising Ph0 edge ending that cycle.
- InData format:
  - [7:0] RxByte
  - [8] RxValid
  - [29] FrameErr (sticky)
  - [30] TxFull
  - [31] RxOvr (sticky)
  - all other bits 0
- InData is stable throughout a cycle: it changes only at Ph0 edges.
- Bit 31 lets software test RxOvr with the ALU sign skip.
- InStrobe with RxValid=1: the edge clears RxValid, RxOvr and FrameErr; RxByte is retained.
- InStrobe with RxValid=0: status-only read; clears RxOvr and FrameErr, no other effect. Software uses this to poll TxFull.
- OutStrobe, FIFO not full: OutData[7:0] is pushed. Bits [31:8] are ignored.
- OutStrobe, FIFO full: the word is dropped and FIFO contents are unchanged. TxFull already warned software.
- InStrobe and OutStrobe are mutually exclusive by decode. If both are high, both actions are taken independently.
- TX engine states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. The pop happens on the same edge as leaving IDLE.
  - START drives 0, DATA drives bits 0..7 LSB first, STOP drives 1. Each state lasts exactly ClkDiv cycles.
  - STOP returns to IDLE. Back-to-back bytes therefore have no extra idle bit.
  - The first start-bit edge on Txd occurs 2 cycles after the OutStrobe edge into an empty FIFO.
- FIFO count rules:
  - Push and pop on the same edge leave the count unchanged.
  - A push into a full FIFO coinciding with a pop is accepted.
  - TxFull = (count == TxDepth).
  - Pointers wrap modulo TxDepth.
- RX engine: Rxd passes through a 2-flop synchronizer. States: IDLE, START, DATA, STOP.
  - IDLE to START on synchronized Rxd=0.
  - START: sample at ClkDiv/2 (integer). If the sample is 1, it is a glitch: return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits, each ClkDiv cycles after the previous sample.
  - STOP: sample one stop bit ClkDiv cycles later.
    - Stop=1: load RxByte and set RxValid. If RxValid was already 1, also set RxOvr; the new byte overwrites the old one.
    - Stop=0: set FrameErr, discard the byte, RxValid unchanged; wait for Rxd=1 before re-entering IDLE.
- Simultaneous RX completion and InStrobe pop: the new byte wins. RxValid=1, RxByte=new, RxOvr=0; the pop cleared the old byte.
- Reset asserted mid-frame: both engines go to IDLE, Txd returns to 1 immediately, and the partial RX byte is lost.
- Bit counters are 3 bits. Baud counters are ceil(log2(ClkDiv)) bits and reload at ClkDiv-1.

Decomposition:
- Shared package tc_io_pkg holds:
  - TX and RX state encodings (2 bits each)
  - InData bit-position constants (RXVALID=8, FRAMEERR=29, TXFULL=30, RXOVR=31)
  - default ClkDiv
- One sub-module, tc_io_fifo: parameterized byte FIFO with push/pop/full/empty/count and same-cycle push+pop. Instantiated once for TX.
- RX and TX engines stay inline.

Test Plan:
- Reset low mid-TX-frame, then released -> Txd=1 immediately, InData=0x00000000, InRdy=0.
- OutStrobe with OutData=0xDEADBE55 into an empty FIFO -> Txd frame 0,1,0,1,0,1,0,1,0,1 (0x55 LSB first), each bit ClkDiv cycles; InData[30]=0 throughout.
- Five OutStrobes 0x01..0x05 on consecutive cycles, TxDepth=4 -> first word popped on the edge after push 1, so 0x01..0x05 are all accepted and TxFull=1 after push 5. A sixth push 0x06 is dropped. Txd sends 01,02,03,04,05 back-to-back.
- Drive Rxd byte 0xA3, then an InStrobe -> InRdy=1, InData=0x000001A3 before the strobe; after it InRdy=0, InData=0x000000A3.
- Receive 0x11 then 0x22 with no InStrobe -> InData=0x80000122. InStrobe -> InData=0x00000022.
- Rxd byte with stop bit 0 -> InData[29]=1, RxValid unchanged. Then 1-cycle low glitches on Rxd -> no byte received. InStrobe clears bit 29.

Source files
------------

// File: rtl/tc_io_pkg.sv
// ---------------------------------------------------------------------------
// tc_io_pkg
// Shared definitions for the TinyComp UART I/O responder:
//   - TX / RX engine state encodings (2 bits each)
//   - bit positions of the status flags inside the InData word
//   - default baud divider (50 MHz / 115200)
//   - debug snapshot struct exposing both engine states
//   - helper that assembles the InData word from its fields
// ---------------------------------------------------------------------------
package tc_io_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int RXVALID  = 8;
    localparam int FRAMEERR = 29;
    localparam int TXFULL   = 30;
    localparam int RXOVR    = 31;

    localparam int CLK_DIV_DEFAULT = 434;

    // Snapshot of both engines, for checkers bound onto the top level.
    typedef struct packed {
        tx_state_t  tx_state;
        logic [2:0] tx_bit;
        rx_state_t  rx_state;
        logic [2:0] rx_bit;
        logic       rx_wait_high;
    } tc_io_dbg_t;

    // InData layout: [7:0] byte, [8] valid, [29] frame error,
    // [30] TX FIFO full, [31] overrun (sign bit, so software can skip on it).
    function automatic logic [31:0] pack_in_data(
        input logic [7:0] rx_byte,
        input logic       rx_valid,
        input logic       frame_err,
        input logic       tx_full,
        input logic       rx_ovr
    );
        logic [31:0] w;
        w           = '0;
        w[7:0]      = rx_byte;
        w[RXVALID]  = rx_valid;
        w[FRAMEERR] = frame_err;
        w[TXFULL]   = tx_full;
        w[RXOVR]    = rx_ovr;
        return w;
    endfunction

endpackage

// File: rtl/tc_io_fifo.sv
// ---------------------------------------------------------------------------
// tc_io_fifo
// Small synchronous FIFO with same-cycle push and pop.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, push_data  : write request and data
//   pop, pop_data    : read request; pop_data shows the head (valid when !empty)
//   full, empty      : occupancy flags
//   count            : number of stored entries (0..Depth)
// A push while full is accepted only if a pop happens on the same edge;
// otherwise it is dropped. A pop while empty is ignored. Depth must be a
// power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module tc_io_fifo #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    output logic [Width-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int PW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (PW + 1)'(Depth));
    assign empty    = (count == '0);

endmodule

// File: rtl/tc_uart_io.sv
// ---------------------------------------------------------------------------
// tc_uart_io
// Responder end of the TinyComp I/O interface, bridged to an 8N1 UART.
//   Ph0        : system clock, all state changes on its rising edge
//   Reset      : asynchronous, active-low
//   OutStrobe  : processor Output this cycle; OutData[7:0] goes to the TX FIFO
//   OutData    : output word (bits [31:8] ignored)
//   InStrobe   : processor Input this cycle; clears RxValid/RxOvr/FrameErr
//   InData     : {RxOvr, TxFull, FrameErr, 20'b0, RxValid, RxByte}
//   InRdy      : a received byte is waiting (RxValid)
//   Txd        : UART transmit line, idle high
//   Rxd        : UART receive line, asynchronous to Ph0
//
// Handshake: a strobe is a single-cycle request that is always accepted; its
// effect lands on the Ph0 edge that ends the strobe cycle. There is no ready
// signal back to the processor: InRdy and InData[30] (TxFull) are status that
// software polls before strobing, and an Output into a full FIFO is dropped.
// ---------------------------------------------------------------------------
module tc_uart_io
    import tc_io_pkg::*;
#(
    parameter int ClkDiv  = CLK_DIV_DEFAULT,
    parameter int TxDepth = 4
) (
    input  logic        Ph0,
    input  logic        Reset,
    input  logic        OutStrobe,
    input  logic [31:0] OutData,
    input  logic        InStrobe,
    output logic [31:0] InData,
    output logic        InRdy,
    output logic        Txd,
    input  logic        Rxd
);

    localparam int BAUD_W = $clog2(ClkDiv);
    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(ClkDiv - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(ClkDiv / 2 - 1);
    localparam int CNT_W = $clog2(TxDepth) + 1;

    // ---------------- TX FIFO ----------------
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;

    tx_state_t        tx_state;
    logic [BAUD_W-1:0] tx_baud;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             txd_q;

    // The head leaves the FIFO on the same edge the engine leaves IDLE.
    assign fifo_pop = (tx_state == TX_IDLE) && !fifo_empty;

    tc_io_fifo #(
        .Depth (TxDepth),
        .Width (8)
    ) u_tx_fifo (
        .clk       (Ph0),
        .rst_n     (Reset),
        .push      (OutStrobe),
        .push_data (OutData[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- TX engine ----------------
    // Txd is registered from the current state, so the line lags the state by
    // one cycle: start bit appears two edges after the push into an empty FIFO.
    always_ff @(posedge Ph0 or negedge Reset) begin
        if (!Reset) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
        end else begin
            case (tx_state)
                TX_START: txd_q <= 1'b0;
                TX_DATA:  txd_q <= tx_shift[0];
                default:  txd_q <= 1'b1;
            endcase

            case (tx_state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_shift <= fifo_head;
                        tx_baud  <= BAUD_FULL;
                        tx_bit   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_baud == '0) begin
                        tx_baud  <= BAUD_FULL;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_baud <= tx_baud - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_baud == '0) begin
                        tx_baud  <= BAUD_FULL;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 1'b1;
                        if (tx_bit == 3'd7) tx_state <= TX_STOP;
                    end else begin
                        tx_baud <= tx_baud - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_baud == '0) tx_state <= TX_IDLE;
                    else               tx_baud  <= tx_baud - 1'b1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX engine ----------------
    logic              rx_s1;
    logic              rx_s2;
    rx_state_t         rx_state;
    logic [BAUD_W-1:0] rx_baud;
    logic [2:0]        rx_bit;
    logic [7:0]        rx_shift;
    logic              rx_wait_high;
    logic              rx_tick;
    logic              rx_done;
    logic              rx_bad;

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ovr;
    logic              frame_err;

    assign rx_tick = (rx_baud == '0);
    // Stop-bit sample point: good frame or framing error.
    assign rx_done = (rx_state == RX_STOP) && !rx_wait_high && rx_tick &&  rx_s2;
    assign rx_bad  = (rx_state == RX_STOP) && !rx_wait_high && rx_tick && !rx_s2;

    always_ff @(posedge Ph0 or negedge Reset) begin
        if (!Reset) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_baud      <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_wait_high <= 1'b0;
        end else begin
            rx_s1 <= Rxd;
            rx_s2 <= rx_s1;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        rx_baud  <= BAUD_HALF;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Mid-start-bit check rejects short low glitches.
                    if (rx_tick) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_baud  <= BAUD_FULL;
                            rx_bit   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_baud <= rx_baud - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_baud  <= BAUD_FULL;
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_baud <= rx_baud - 1'b1;
                    end
                end
                RX_STOP: begin
                    // After a framing error, hold here until the line returns
                    // high so a break is not taken as a new start bit.
                    if (rx_wait_high) begin
                        if (rx_s2) begin
                            rx_wait_high <= 1'b0;
                            rx_state     <= RX_IDLE;
                        end
                    end else if (rx_tick) begin
                        if (rx_s2) rx_state     <= RX_IDLE;
                        else       rx_wait_high <= 1'b1;
                    end else begin
                        rx_baud <= rx_baud - 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Holding register and sticky flags. A completing byte beats a same-edge
    // InStrobe; overrun is only flagged when the old byte was not read.
    always_ff @(posedge Ph0 or negedge Reset) begin
        if (!Reset) begin
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (InStrobe) begin
                rx_valid <= 1'b0;
            end

            if (rx_done && rx_valid && !InStrobe) rx_ovr <= 1'b1;
            else if (InStrobe)                    rx_ovr <= 1'b0;

            if (rx_bad)        frame_err <= 1'b1;
            else if (InStrobe) frame_err <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign InData = pack_in_data(rx_byte, rx_valid, frame_err, fifo_full, rx_ovr);
    assign InRdy  = rx_valid;
    assign Txd    = txd_q;

    tc_io_dbg_t fsm_dbg_unused;
    assign fsm_dbg_unused = '{
        tx_state:     tx_state,
        tx_bit:       tx_bit,
        rx_state:     rx_state,
        rx_bit:       rx_bit,
        rx_wait_high: rx_wait_high
    };

    logic unused_inputs;
    assign unused_inputs = ^{OutData[31:8], fifo_count};

endmodule

// File: tb/tb_tc_uart_io.sv
// ---------------------------------------------------------------------------
// tb_tc_uart_io
// Directed bench for tc_uart_io with a short baud divider. Inputs are driven
// on the falling edge; TX bytes and InStrobe reads are checked by monitors
// against expected queues filled by the drivers.
// ---------------------------------------------------------------------------
module tb_tc_uart_io;

    localparam int CLK_DIV  = 16;
    localparam int TX_DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        Ph0       = 1'b0;
    logic        Reset     = 1'b0;
    logic        OutStrobe = 1'b0;
    logic [31:0] OutData   = '0;
    logic        InStrobe  = 1'b0;
    logic        Rxd       = 1'b1;
    logic [31:0] InData;
    logic        InRdy;
    logic        Txd;

    always #5 Ph0 = ~Ph0;

    tc_uart_io #(
        .ClkDiv  (CLK_DIV),
        .TxDepth (TX_DEPTH)
    ) dut (
        .Ph0       (Ph0),
        .Reset     (Reset),
        .OutStrobe (OutStrobe),
        .OutData   (OutData),
        .InStrobe  (InStrobe),
        .InData    (InData),
        .InRdy     (InRdy),
        .Txd       (Txd),
        .Rxd       (Rxd)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  tx_exp_q[$];
    logic [31:0] rd_exp_q[$];
    bit          tx_mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge Ph0);
    endtask

    task automatic in_read(input logic [31:0] exp);
        @(negedge Ph0);
        InStrobe = 1'b1;
        rd_exp_q.push_back(exp);
        @(negedge Ph0);
        InStrobe = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge Ph0);
            Rxd = f[i];
            repeat (CLK_DIV - 1) @(negedge Ph0);
        end
        @(negedge Ph0);
        Rxd = 1'b1;
    endtask

    task automatic wait_tx_drain(input int budget);
        int n;
        n = 0;
        while (tx_exp_q.size() != 0 && n < budget) begin
            @(negedge Ph0);
            n++;
        end
        check("tx_drain_pending", 32'(tx_exp_q.size()), 32'd0);
        tx_exp_q.delete();
        cycles(2 * CLK_DIV);
    endtask

    // ---------------- monitors ----------------
    // Decodes Txd frames, sampling each bit at its centre.
    initial begin : tx_monitor
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge Ph0);
            if (tx_mon_en && Txd == 1'b0) begin
                repeat (CLK_DIV / 2 - 1) @(negedge Ph0);
                check("tx_start_bit", {31'b0, Txd}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge Ph0);
                    b[i] = Txd;
                end
                repeat (CLK_DIV) @(negedge Ph0);
                check("tx_stop_bit", {31'b0, Txd}, 32'd1);
                if (tx_exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected_byte: got %02h, expected no frame", b);
                end else begin
                    check("tx_byte", {24'b0, b}, {24'b0, tx_exp_q.pop_front()});
                end
            end
        end
    end

    // Compares InData during every InStrobe cycle.
    initial begin : rd_monitor
        forever begin
            @(negedge Ph0);
            #2;
            if (InStrobe) begin
                if (rd_exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL in_read_unexpected: got %08h, expected no read", InData);
                end else begin
                    check("in_read", InData, rd_exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        // reset values
        cycles(3);
        check("reset_txd",    {31'b0, Txd},   32'd1);
        check("reset_indata", InData,         32'h0000_0000);
        check("reset_inrdy",  {31'b0, InRdy}, 32'd0);
        @(negedge Ph0);
        Reset = 1'b1;

        // reset in the middle of a frame of 0x00 (line low through data bits)
        @(negedge Ph0);
        OutStrobe = 1'b1;
        OutData   = 32'h1234_5600;
        @(negedge Ph0);
        OutStrobe = 1'b0;
        OutData   = '0;
        cycles(40);
        check("txd_mid_frame", {31'b0, Txd}, 32'd0);
        @(negedge Ph0);
        Reset = 1'b0;
        #1;
        check("async_reset_txd",    {31'b0, Txd},   32'd1);
        check("async_reset_indata", InData,         32'h0000_0000);
        check("async_reset_inrdy",  {31'b0, InRdy}, 32'd0);
        cycles(2);
        Reset = 1'b1;
        cycles(30);
        check("idle_after_reset_txd",    {31'b0, Txd}, 32'd1);
        check("idle_after_reset_indata", InData,       32'h0000_0000);
        tx_mon_en = 1'b1;

        // single word, start-bit latency, upper bits ignored
        @(negedge Ph0);
        OutStrobe = 1'b1;
        OutData   = 32'hDEAD_BE55;
        tx_exp_q.push_back(8'h55);
        @(negedge Ph0);
        OutStrobe = 1'b0;
        OutData   = '0;
        check("txd_latency_1", {31'b0, Txd}, 32'd1);
        @(negedge Ph0);
        check("txd_latency_2", {31'b0, Txd}, 32'd1);
        @(negedge Ph0);
        check("txd_start_edge", {31'b0, Txd}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycles(35);
            check("txfull_during_frame", InData, 32'h0000_0000);
        end
        wait_tx_drain(400);

        // five back-to-back pushes fill the FIFO, sixth is dropped
        for (int i = 1; i <= 6; i++) begin
            @(negedge Ph0);
            if (i == 6) check("txfull_after_5", InData, 32'h4000_0000);
            OutStrobe = 1'b1;
            OutData   = {24'hFFFFFF, 8'(i)};
            if (i <= 5) tx_exp_q.push_back(8'(i));
        end
        @(negedge Ph0);
        OutStrobe = 1'b0;
        OutData   = '0;
        check("txfull_after_drop", InData, 32'h4000_0000);
        wait_tx_drain(2000);
        check("txfull_cleared", InData, 32'h0000_0000);

        // receive one byte, then read it
        rx_frame(8'hA3, 1'b1);
        cycles(4);
        check("inrdy_after_rx", {31'b0, InRdy}, 32'd1);
        in_read(32'h0000_01A3);
        check("inrdy_after_read", {31'b0, InRdy}, 32'd0);
        in_read(32'h0000_00A3);

        // two bytes without a read: overrun, newest byte kept
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        cycles(4);
        in_read(32'h8000_0122);
        in_read(32'h0000_0022);

        // good byte, then a frame with a bad stop bit, then short glitches
        rx_frame(8'h33, 1'b1);
        cycles(4);
        rx_frame(8'h5A, 1'b0);
        cycles(4);
        check("frame_err_inrdy", {31'b0, InRdy}, 32'd1);
        for (int g = 0; g < 3; g++) begin
            @(negedge Ph0);
            Rxd = 1'b0;
            @(negedge Ph0);
            Rxd = 1'b1;
            cycles(30);
        end
        in_read(32'h2000_0133);
        in_read(32'h0000_0033);

        cycles(5);
        check("rd_queue_pending", 32'(rd_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
